// File: rtl/data_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_master_pkg
// Shared types and constants for the memory-stage bus master.
//   bus_state_t : transaction FSM states
//   DEV_MEM/DEV_FP : device select codes carried in address bits [15:12]
//   BUS_W       : bus address/data width
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package data_bus_master_pkg;

  localparam int BUS_W = 16;

  localparam logic [3:0] DEV_MEM = 4'h0;
  localparam logic [3:0] DEV_FP  = 4'h1;

  typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} bus_state_t;

endpackage

// File: rtl/data_bus_master_if.sv
// -----------------------------------------------------------------------------
// data_bus_master_if
// Groups the pipeline request/response handshake and the avalon-side bus
// signals of the data bus master.
//   master modport : the bus master's view (drives strobes, address, response)
//   slave  modport : the environment's view (pipeline + bus slave)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface data_bus_master_if;

  // pipeline side
  logic                                  ReqValid;
  logic                                  ReqWrite;
  logic [data_bus_master_pkg::BUS_W-1:0] ReqAddr;
  logic [data_bus_master_pkg::BUS_W-1:0] ReqWdata;
  logic                                  Stall;
  logic                                  RespValid;
  logic [data_bus_master_pkg::BUS_W-1:0] RespData;
  logic                                  BusErr;
  logic                                  ErrSticky;

  // bus side
  logic [data_bus_master_pkg::BUS_W-1:0] DataAddr;
  logic [data_bus_master_pkg::BUS_W-1:0] BusWrData;
  logic [data_bus_master_pkg::BUS_W-1:0] BusRdData;
  logic                                  ReadData;
  logic                                  WriteData;
  logic                                  Waitreq;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqWdata, BusRdData, Waitreq,
    output Stall, RespValid, RespData, BusErr, ErrSticky,
           DataAddr, BusWrData, ReadData, WriteData
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqWdata, BusRdData, Waitreq,
    input  Stall, RespValid, RespData, BusErr, ErrSticky,
           DataAddr, BusWrData, ReadData, WriteData
  );

endinterface

// File: rtl/data_bus_master.sv
// -----------------------------------------------------------------------------
// data_bus_master
// Memory-stage bus master: takes one load/store from the pipeline, presents
// it on the bus until Waitreq drops, waits out the fixed read latency, then
// issues a one-cycle response. A request stuck behind Waitreq is aborted after
// TIMEOUT_CYCLES cycles with BusErr and a sticky error flag.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : data_bus_master_if.master (pipeline handshake + bus signals)
//
// Parameters:
//   READ_LATENCY   : 0..7 cycles from read acceptance to valid BusRdData
//   TIMEOUT_CYCLES : 1..255 Waitreq-high cycles tolerated in REQ
//
// State | Meaning
// IDLE  | waiting for ReqValid; latches the request when it appears
// REQ   | strobe on bus, holding address/data until Waitreq is low
// LAT   | read accepted, counting down to the read-data cycle
// DONE  | one-cycle response, pipeline released
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module data_bus_master
  import data_bus_master_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  data_bus_master_if.master      bus
);

  // Counter load/compare values; LAT is never entered when READ_LATENCY is 0.
  localparam logic [2:0] LCNT_INIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  bus_state_t         state_q, state_d;
  logic               wr_q, wr_d;
  logic [BUS_W-1:0]   addr_q, addr_d;
  logic [BUS_W-1:0]   wdata_q, wdata_d;
  logic [BUS_W-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [7:0]         tcnt_q, tcnt_d;
  logic [2:0]         lcnt_q, lcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      tcnt_q   <= '0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      tcnt_q   <= tcnt_d;
      lcnt_q   <= lcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    tcnt_d   = tcnt_q;
    lcnt_d   = lcnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          addr_d  = bus.ReqAddr;
          wdata_d = bus.ReqWdata;
          wr_d    = bus.ReqWrite;
          tcnt_d  = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        if (!bus.Waitreq) begin
          if (wr_q) begin
            state_d = DONE;
          end else if (READ_LATENCY == 0) begin
            rdata_d = bus.BusRdData;
            state_d = DONE;
          end else begin
            lcnt_d  = LCNT_INIT;
            state_d = LAT;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          // Abort: the response carries zero data and the error pulse.
          rdata_d  = '0;
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      LAT: begin
        if (lcnt_q == 3'd0) begin
          rdata_d = bus.BusRdData;
          state_d = DONE;
        end else begin
          lcnt_d = lcnt_q - 3'd1;
        end
      end

      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state flop so an async reset drops them
  // in the same cycle.
  assign bus.ReadData  = (state_q == REQ) && !wr_q;
  assign bus.WriteData = (state_q == REQ) &&  wr_q;

  assign bus.Stall     = (state_q == IDLE) ? bus.ReqValid : (state_q != DONE);
  assign bus.RespValid = (state_q == DONE);
  assign bus.BusErr    = err_q;
  assign bus.ErrSticky = sticky_q;
  assign bus.RespData  = rdata_q;
  assign bus.DataAddr  = addr_q;
  assign bus.BusWrData = wdata_q;

endmodule

// File: tb/tb_data_bus_master.sv
`timescale 1ns/1ps
module tb_data_bus_master;
  import data_bus_master_pkg::*;

  localparam int LAT = 1;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_bus_master_if bus();

  data_bus_master #(.READ_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One expected-output record per clock cycle; k is the cycle index inside
  // a transaction (0 = request cycle), -1 for idle cycles.
  typedef struct {
    int          k;
    bit          stall, rd, wr, rv, err, sticky, in_req;
    logic [15:0] addr, wdata, rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem [logic [15:0]];
  bit          sticky_m = 1'b0;
  logic [15:0] resp_m   = 16'h0;

  int          obs_rd, obs_wr, obs_stall, obs_resp_k, obs_err;
  logic [15:0] obs_resp_data;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare process: checks every cycle that has a model entry.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.k == 0) begin
        obs_rd = 0; obs_wr = 0; obs_stall = 0; obs_resp_k = -1; obs_err = 0;
        obs_resp_data = 16'hxxxx;
      end
      if (cur.k >= 0) begin
        if (bus.ReadData === 1'b1)  obs_rd++;
        if (bus.WriteData === 1'b1) obs_wr++;
        if (bus.Stall === 1'b1)     obs_stall++;
        if (bus.RespValid === 1'b1) begin
          obs_resp_k    = cur.k;
          obs_resp_data = bus.RespData;
          obs_err       = (bus.BusErr === 1'b1) ? 1 : 0;
        end
      end
      chk("stall",      16'(bus.Stall),     16'(cur.stall));
      chk("read_strb",  16'(bus.ReadData),  16'(cur.rd));
      chk("write_strb", 16'(bus.WriteData), 16'(cur.wr));
      chk("resp_valid", 16'(bus.RespValid), 16'(cur.rv));
      chk("bus_err",    16'(bus.BusErr),    16'(cur.err));
      chk("err_sticky", 16'(bus.ErrSticky), 16'(cur.sticky));
      chk("resp_data",  bus.RespData,       cur.rdata);
      if (cur.in_req) begin
        chk("data_addr",   bus.DataAddr,  cur.addr);
        chk("bus_wr_data", bus.BusWrData, cur.wdata);
      end
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    exp_t e;
    @(posedge clk); #1;
    bus.ReqValid  = 1'b0;
    bus.ReqWrite  = 1'($urandom);
    bus.ReqAddr   = 16'($urandom);
    bus.ReqWdata  = 16'($urandom);
    bus.Waitreq   = 1'($urandom);
    bus.BusRdData = 16'($urandom);
    e.k = -1; e.stall = 1'b0; e.rd = 1'b0; e.wr = 1'b0; e.rv = 1'b0; e.err = 1'b0;
    e.sticky = sticky_m; e.in_req = 1'b0; e.addr = 16'h0; e.wdata = 16'h0; e.rdata = resp_m;
    exp_q.push_back(e);
  endtask

  // Transaction-level model: w = number of Waitreq-high cycles the slave
  // inserts; w >= TMO means the slave never answers in time.
  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata, input int w);
    bit          tmo;
    int          nreq, nlat, total;
    logic [15:0] rdv;
    exp_t        e;
    tmo   = (w >= TMO);
    nreq  = tmo ? TMO : w + 1;
    nlat  = (wr || tmo) ? 0 : LAT;
    total = nreq + nlat + 2;
    rdv   = mem.exists(addr) ? mem[addr] : 16'h0;
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      bus.ReqValid  = 1'b1;
      bus.ReqWrite  = wr;
      bus.ReqAddr   = addr;
      bus.ReqWdata  = wdata;
      bus.Waitreq   = (k >= 1 && k <= nreq) ? (k - 1 < w) : 1'($urandom);
      bus.BusRdData = (!wr && !tmo && k == nreq + LAT) ? rdv : 16'($urandom);
      if (k == total - 1) begin
        if (tmo) begin
          sticky_m = 1'b1;
          resp_m   = 16'h0;
        end else if (!wr) begin
          resp_m = rdv;
        end
      end
      e.k      = k;
      e.stall  = (k < total - 1);
      e.in_req = (k >= 1 && k <= nreq);
      e.rd     = !wr && e.in_req;
      e.wr     =  wr && e.in_req;
      e.rv     = (k == total - 1);
      e.err    = e.rv && tmo;
      e.sticky = sticky_m;
      e.addr   = addr;
      e.wdata  = wdata;
      e.rdata  = resp_m;
      exp_q.push_back(e);
    end
    if (wr && !tmo) mem[addr] = wdata;
  endtask

  initial begin
    bit          wr;
    int          w, r;
    logic [15:0] addr;

    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqAddr = 16'h0; bus.ReqWdata = 16'h0;
    bus.Waitreq  = 1'b0; bus.BusRdData = 16'h0;
    rst = 1'b1;
    #2;
    chk("rst_stall",      16'(bus.Stall),     16'd0);
    chk("rst_read_strb",  16'(bus.ReadData),  16'd0);
    chk("rst_write_strb", 16'(bus.WriteData), 16'd0);
    chk("rst_resp_valid", 16'(bus.RespValid), 16'd0);
    chk("rst_bus_err",    16'(bus.BusErr),    16'd0);
    chk("rst_err_sticky", 16'(bus.ErrSticky), 16'd0);
    chk("rst_resp_data",  bus.RespData,       16'h0);
    chk("rst_data_addr",  bus.DataAddr,       16'h0);
    chk("rst_wr_data",    bus.BusWrData,      16'h0);
    @(negedge clk);
    rst = 1'b0;

    mem[16'h0020]            = 16'h1234;
    mem[{DEV_FP, 12'h002}]   = 16'hCAFE;

    // store, no wait
    do_txn(1'b1, 16'h0010, 16'hBEEF, 0); settle();
    chk("store_wr_cycles",  16'(obs_wr),     16'd1);
    chk("store_rd_cycles",  16'(obs_rd),     16'd0);
    chk("store_stall_cyc",  16'(obs_stall),  16'd2);
    chk("store_resp_cycle", 16'(obs_resp_k), 16'd2);
    chk("store_addr_held",  bus.DataAddr,    16'h0010);
    chk("store_data_held",  bus.BusWrData,   16'hBEEF);

    // load, latency 1
    do_txn(1'b0, 16'h0020, 16'h5555, 0); settle();
    chk("load_rd_cycles",  16'(obs_rd),     16'd1);
    chk("load_resp_cycle", 16'(obs_resp_k), 16'd3);
    chk("load_resp_data",  obs_resp_data,   16'h1234);
    chk("load_bus_err",    16'(obs_err),    16'd0);

    // FP load with three wait cycles
    do_txn(1'b0, {DEV_FP, 12'h002}, 16'h0000, 3); settle();
    chk("fp_rd_cycles",  16'(obs_rd),     16'd4);
    chk("fp_stall_cyc",  16'(obs_stall),  16'd6);
    chk("fp_resp_cycle", 16'(obs_resp_k), 16'd6);
    chk("fp_resp_data",  obs_resp_data,   16'hCAFE);
    idle_cycle();

    // timeout
    do_txn(1'b0, 16'h0040, 16'h0000, 9); settle();
    chk("tmo_rd_cycles", 16'(obs_rd),        16'd4);
    chk("tmo_bus_err",   16'(obs_err),       16'd1);
    chk("tmo_resp_data", obs_resp_data,      16'h0000);
    chk("tmo_sticky",    16'(bus.ErrSticky), 16'd1);

    // back-to-back store then load of the same word
    do_txn(1'b1, 16'h0000, 16'h0001, 0); settle();
    do_txn(1'b0, 16'h0000, 16'hFFFF, 0); settle();
    chk("b2b_resp_data",   obs_resp_data,      16'h0001);
    chk("b2b_sticky_kept", 16'(bus.ErrSticky), 16'd1);

    // reset in the middle of a waited read
    idle_cycle(); settle();
    @(posedge clk); #1;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqAddr = 16'h0030; bus.Waitreq = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_pre_strb", 16'(bus.ReadData), 16'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_read_strb",  16'(bus.ReadData),  16'd0);
    chk("rst_mid_write_strb", 16'(bus.WriteData), 16'd0);
    chk("rst_mid_resp_valid", 16'(bus.RespValid), 16'd0);
    bus.ReqValid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    sticky_m = 1'b0;
    resp_m   = 16'h0;
    repeat (3) idle_cycle();
    settle();
    chk("rst_mid_sticky", 16'(bus.ErrSticky), 16'd0);
    chk("rst_mid_addr",   bus.DataAddr,       16'h0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      wr   = 1'($urandom);
      addr = {($urandom_range(0, 1) != 0) ? DEV_FP : DEV_MEM, 8'h00, 4'($urandom)};
      r    = $urandom_range(0, 9);
      w    = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 3) : $urandom_range(4, 6);
      do_txn(wr, addr, 16'($urandom), w);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    repeat (2) idle_cycle();
    settle();
    chk("model_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
